bcd_updown_timer: RTL and testbench

- Multi-digit BCD up/down counter and timer, built from the existing combinational digit cell `tick`, one instance per digit.
- Advances the displayed count from one of two sources:
  - an internal prescaler while running;
  - single-step pulses from the upstream debouncer while paused.
- Supports clear, parallel load and wrap reporting.
- Its output feeds the seven-segment display driver.

---
 rtl/bcd_pkg.sv | 19 +
 rtl/tick.sv | 23 ++
 rtl/bcd_updown_timer.sv | 123 ++++++++++++
 tb/tb_bcd_updown_timer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD constants, run/pause state encoding and a digit validity helper
// for the up/down timer and its digit cells.
package bcd_pkg;

    localparam int          BCD_W    = 4;
    localparam logic [3:0]  BCD_MAX  = 4'd9;
    localparam logic        DIR_UP   = 1'b1;
    localparam logic        DIR_DOWN = 1'b0;

    typedef enum logic {
        PAUSED  = 1'b0,
        RUNNING = 1'b1
    } state_e;

    function automatic logic bcd_valid(input logic [BCD_W-1:0] digit);
        return (digit <= BCD_MAX);
    endfunction

endpackage

// File: rtl/tick.sv
// Combinational single-digit BCD step cell: when enabled, moves one digit up
// or down by one, wrapping 9->0 (up) and 0->9 (down); otherwise holds.
module tick
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] digit_i,
    input  logic             en_i,
    input  logic             sign_i,
    output logic [BCD_W-1:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (en_i) begin
            if (sign_i == DIR_UP) begin
                digit_o = (digit_i >= BCD_MAX) ? '0 : digit_i + 4'd1;
            end else begin
                digit_o = (digit_i == '0) ? BCD_MAX : digit_i - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_updown_timer.sv
// Multi-digit BCD up/down timer: a prescaler drives steps while running,
// manual step pulses drive them while paused; supports clear, load and wrap.
module bcd_updown_timer
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 100000,
    parameter int PRESCALE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_stop,
    input  logic                        clear,
    input  logic                        load,
    input  logic [BCD_W*NUM_DIGITS-1:0] load_value,
    input  logic                        dir,
    input  logic                        step,
    output logic [BCD_W*NUM_DIGITS-1:0] count,
    output logic                        running,
    output logic                        wrap,
    output logic                        load_err
);

    localparam int CW = BCD_W * NUM_DIGITS;

    state_e                state_q, state_d;
    logic                  running_q;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  wrap_q, wrap_d;
    logic                  load_err_q, load_err_d;

    logic                  presc_term;
    logic                  step_en;
    logic [NUM_DIGITS:0]   carry;
    logic [CW-1:0]         tick_count;
    logic [CW-1:0]         load_clean;
    logic [NUM_DIGITS-1:0] load_bad;

    // Step source follows the current registered state, so a terminal count
    // that coincides with a stop pulse still advances the count.
    assign presc_term = (state_q == RUNNING) &&
                        (presc_q == PRESCALE_W'(PRESCALE - 1));
    assign step_en    = (state_q == RUNNING) ? presc_term : step;
    assign carry[0]   = step_en;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [BCD_W-1:0] digit_cur;
            logic [BCD_W-1:0] digit_ld;
            logic             at_limit;

            assign digit_cur = count_q[gi*BCD_W +: BCD_W];
            assign digit_ld  = load_value[gi*BCD_W +: BCD_W];
            assign at_limit  = (dir == DIR_UP) ? (digit_cur == BCD_MAX)
                                               : (digit_cur == '0);
            // Higher digit moves only when all lower digits roll over.
            assign carry[gi+1] = carry[gi] & at_limit;

            assign load_bad[gi] = !bcd_valid(digit_ld);
            assign load_clean[gi*BCD_W +: BCD_W] = load_bad[gi] ? '0 : digit_ld;

            tick u_tick (
                .digit_i (digit_cur),
                .en_i    (carry[gi]),
                .sign_i  (dir),
                .digit_o (tick_count[gi*BCD_W +: BCD_W])
            );
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        count_d    = count_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;

        if (start_stop) begin
            state_d = (state_q == RUNNING) ? PAUSED : RUNNING;
        end

        if (state_q == RUNNING) begin
            presc_d = presc_term ? '0 : presc_q + PRESCALE_W'(1);
        end

        if (clear) begin
            count_d = '0;
            presc_d = '0;
        end else if (load) begin
            count_d    = load_clean;
            presc_d    = '0;
            load_err_d = |load_bad;
        end else if (step_en) begin
            count_d = tick_count;
            wrap_d  = carry[NUM_DIGITS];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PAUSED;
            running_q  <= 1'b0;
            presc_q    <= '0;
            count_q    <= '0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            running_q  <= (state_d == RUNNING);
            presc_q    <= presc_d;
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign count    = count_q;
    assign running  = running_q;
    assign wrap     = wrap_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_updown_timer.sv
// Directed bench for bcd_updown_timer with a short prescaler: vector table
// for paused-mode behaviour plus hand sequences for running and reset.
module tb_bcd_updown_timer;

    logic        clk;
    logic        rst_n;
    logic        start_stop;
    logic        clear;
    logic        load;
    logic [15:0] load_value;
    logic        dir;
    logic        step;
    logic [15:0] count;
    logic        running;
    logic        wrap;
    logic        load_err;

    int checks = 0;
    int errors = 0;

    bcd_updown_timer #(
        .NUM_DIGITS (4),
        .PRESCALE   (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_stop (start_stop),
        .clear      (clear),
        .load       (load),
        .load_value (load_value),
        .dir        (dir),
        .step       (step),
        .count      (count),
        .running    (running),
        .wrap       (wrap),
        .load_err   (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        clr;
        logic        ld;
        logic [15:0] lv;
        logic        d;
        logic        stp;
        logic        ss;
        logic [15:0] ec;
        logic        ew;
        logic        ele;
        logic        er;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [15:0] ec, input logic ew,
                             input logic ele, input logic er);
        chk({name, ".count"},    {16'h0, count},    {16'h0, ec});
        chk({name, ".wrap"},     {31'h0, wrap},     {31'h0, ew});
        chk({name, ".load_err"}, {31'h0, load_err}, {31'h0, ele});
        chk({name, ".running"},  {31'h0, running},  {31'h0, er});
        $display("%-14s count=%h wrap=%b load_err=%b running=%b", name, count, wrap, load_err, running);
    endtask

    // Drive one cycle of inputs, let one rising edge pass, then idle inputs.
    task automatic cycle(input logic clr, input logic ld, input logic [15:0] lv,
                         input logic d, input logic stp, input logic ss);
        clear = clr; load = ld; load_value = lv; dir = d; step = stp; start_stop = ss;
        @(posedge clk);
        #1;
        clear = 0; load = 0; step = 0; start_stop = 0;
    endtask

    initial begin
        vecs[0]  = '{"ld0099",   0,1,16'h0099,1,0,0, 16'h0099,0,0,0};
        vecs[1]  = '{"up0100",   0,0,16'h0000,1,1,0, 16'h0100,0,0,0};
        vecs[2]  = '{"dn0099",   0,0,16'h0000,0,1,0, 16'h0099,0,0,0};
        vecs[3]  = '{"ld9999",   0,1,16'h9999,1,0,0, 16'h9999,0,0,0};
        vecs[4]  = '{"upwrap",   0,0,16'h0000,1,1,0, 16'h0000,1,0,0};
        vecs[5]  = '{"wrapdrop", 0,0,16'h0000,1,0,0, 16'h0000,0,0,0};
        vecs[6]  = '{"dnwrap",   0,0,16'h0000,0,1,0, 16'h9999,1,0,0};
        vecs[7]  = '{"wrapdrop2",0,0,16'h0000,0,0,0, 16'h9999,0,0,0};
        vecs[8]  = '{"prio_clr", 1,1,16'h0055,1,1,0, 16'h0000,0,0,0};
        vecs[9]  = '{"prio_ld",  0,1,16'h0055,1,1,0, 16'h0055,0,0,0};
        vecs[10] = '{"ld_bad",   0,1,16'hA3F7,1,0,0, 16'h0307,0,1,0};
        vecs[11] = '{"lerr_drop",0,0,16'h0000,1,0,0, 16'h0307,0,0,0};
        vecs[12] = '{"ld1234",   0,1,16'h1234,1,0,0, 16'h1234,0,0,0};
        vecs[13] = '{"dn1233",   0,0,16'h0000,0,1,0, 16'h1233,0,0,0};
        vecs[14] = '{"ld0900",   0,1,16'h0900,0,0,0, 16'h0900,0,0,0};
        vecs[15] = '{"dn0899",   0,0,16'h0000,0,1,0, 16'h0899,0,0,0};
        vecs[16] = '{"up0900",   0,0,16'h0000,1,1,0, 16'h0900,0,0,0};
        vecs[17] = '{"clr",      1,0,16'h0000,1,0,0, 16'h0000,0,0,0};

        rst_n = 0; start_stop = 0; clear = 0; load = 0; load_value = '0; dir = 1; step = 0;
        #12;
        check_all("reset", 16'h0000, 0, 0, 0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        check_all("post_reset", 16'h0000, 0, 0, 0);

        foreach (vecs[i]) begin
            cycle(vecs[i].clr, vecs[i].ld, vecs[i].lv, vecs[i].d, vecs[i].stp, vecs[i].ss);
            check_all(vecs[i].name, vecs[i].ec, vecs[i].ew, vecs[i].ele, vecs[i].er);
        end

        // Running with PRESCALE=3: step pulses are ignored, count +1 every 3 edges.
        cycle(0, 0, 16'h0, 1, 0, 1);
        check_all("start", 16'h0000, 0, 0, 1);
        for (int i = 1; i <= 9; i++) begin
            cycle(0, 0, 16'h0, 1, (i % 2) == 0, 0);
            check_all($sformatf("run%0d", i), 16'(i / 3), 0, 0, 1);
        end
        cycle(0, 0, 16'h0, 1, 0, 0);
        check_all("run_partial", 16'h0003, 0, 0, 1);
        cycle(0, 0, 16'h0, 1, 0, 1);
        check_all("stop", 16'h0003, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            cycle(0, 0, 16'h0, 1, 0, 0);
            check_all("paused_hold", 16'h0003, 0, 0, 0);
        end
        cycle(0, 0, 16'h0, 1, 0, 1);
        check_all("restart", 16'h0003, 0, 0, 1);
        cycle(0, 0, 16'h0, 1, 0, 0);
        check_all("resume_step", 16'h0004, 0, 0, 1);

        // Asynchronous reset mid-count, then no counting until a new start.
        cycle(0, 1, 16'h0042, 1, 0, 0);
        check_all("ld0042", 16'h0042, 0, 0, 1);
        #2;
        rst_n = 0;
        #1;
        check_all("async_rst", 16'h0000, 0, 0, 0);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
        end
        check_all("rst_idle", 16'h0000, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout: got no finish expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
